// File: rtl/shared_gate_arbiter_if.sv
// shared_gate_arbiter_if: requester, shared-gate and status signals of shared_gate_arbiter (err only with SHARED_GATE_ARB_CHECK_EN)
interface shared_gate_arbiter_if #(parameter int N = 4);
  logic [N-1:0] req, op_a, op_b, ack, res;
  logic gate_a, gate_b, gate_y, busy;
`ifdef SHARED_GATE_ARB_CHECK_EN
  logic err;
`endif
  modport slave (
    input req, op_a, op_b, gate_y,
    output gate_a, gate_b, ack, res, busy
`ifdef SHARED_GATE_ARB_CHECK_EN
    , err
`endif
  );
  modport master (
    output req, op_a, op_b, gate_y,
    input gate_a, gate_b, ack, res, busy
`ifdef SHARED_GATE_ARB_CHECK_EN
    , err
`endif
  );
endinterface

// File: rtl/shared_gate_arbiter.sv
// shared_gate_arbiter: round-robin time-sharing of one external AND2 among N requesters; SHARED_GATE_ARB_CHECK_EN adds sticky gate-check err
module shared_gate_arbiter #(
  parameter int N = 4,
  parameter int LAT = 2
) (
  input logic clk,
  input logic rst,
  shared_gate_arbiter_if.slave bus
);
  localparam int PW = $clog2(N);
  logic [N-1:0] pending, elig, grant, op_oh;
  logic [PW-1:0] ptr, ptr_nxt;
  logic [N-1:0] ack_q [LAT];
  logic [N-1:0] res_q [LAT];
  assign elig = bus.req & ~pending;
  assign bus.ack = ack_q[LAT-1];
  assign bus.res = res_q[LAT-1];
  assign bus.busy = |pending;
  // descending scan: the smallest offset from ptr is written last and wins
  always_comb begin
    grant = '0;
    ptr_nxt = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[PW'((int'(ptr) + i) % N)]) begin
        grant = N'(1) << ((int'(ptr) + i) % N);
        ptr_nxt = PW'((int'(ptr) + i + 1) % N);
      end
    end
  end
  // op_oh marks the operand cycle; results travel one-hot so ack/res are plain registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      ptr <= '0;
      op_oh <= '0;
      bus.gate_a <= 1'b0;
      bus.gate_b <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        ack_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      pending <= (pending | grant) & ~bus.ack;
      ptr <= ptr_nxt;
      op_oh <= grant;
      bus.gate_a <= |(grant & bus.op_a);
      bus.gate_b <= |(grant & bus.op_b);
      ack_q[0] <= op_oh;
      res_q[0] <= op_oh & {N{bus.gate_y}};
      for (int k = 1; k < LAT; k++) begin
        ack_q[k] <= ack_q[k-1];
        res_q[k] <= res_q[k-1];
      end
    end
  end
`ifdef SHARED_GATE_ARB_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.err <= 1'b0;
    else if (bus.gate_y != (bus.gate_a & bus.gate_b)) bus.err <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_shared_gate_arbiter.sv
// tb_shared_gate_arbiter: vector table, corner sequences and randomized model check of shared_gate_arbiter
module tb_shared_gate_arbiter;
  localparam int N = 4;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_y = 1'b0;
  always #5 clk = ~clk;
  shared_gate_arbiter_if #(.N(N)) sif();
  shared_gate_arbiter_if #(.N(N)) lif();
  assign sif.gate_y = (sif.gate_a & sif.gate_b) | force_y;
  assign lif.gate_y = lif.gate_a & lif.gate_b;
  shared_gate_arbiter #(.N(N), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(sif));
  shared_gate_arbiter #(.N(N), .LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(lif));
  typedef struct {
    logic r;
    logic [3:0] req, a, b;
    logic ga, gb;
    logic [3:0] ack, res;
    logic busy;
  } vec_t;
  vec_t tbl[21];
  int checks = 0;
  int errors = 0;
  logic [3:0] m_pend, m_ack, m_res;
  logic [3:0] s_ack[16];
  logic [3:0] s_res[16];
  logic m_ga, m_gb;
  int m_ptr, m_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] a, input logic [3:0] b);
    rst = r;
    sif.req = rq;
    sif.op_a = a;
    sif.op_b = b;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_main(input string nm, input logic ga, input logic gb, input logic [3:0] ack,
                          input logic [3:0] res, input logic busy);
    chk({nm, "_gate_a"}, 32'(sif.gate_a), 32'(ga));
    chk({nm, "_gate_b"}, 32'(sif.gate_b), 32'(gb));
    chk({nm, "_ack"}, 32'(sif.ack), 32'(ack));
    chk({nm, "_res"}, 32'(sif.res), 32'(res));
    chk({nm, "_busy"}, 32'(sif.busy), 32'(busy));
  endtask
  // reference: scheduled acks indexed by edge number, rr pointer as plain integer
  task automatic model_edge(input logic r, input logic [3:0] rq, input logic [3:0] a, input logic [3:0] b);
    int w;
    w = -1;
    if (r) begin
      m_pend = '0; m_ptr = 0; m_t = 0; m_ack = '0; m_res = '0; m_ga = 1'b0; m_gb = 1'b0;
      for (int k = 0; k < 16; k++) begin
        s_ack[k] = '0;
        s_res[k] = '0;
      end
      return;
    end
    for (int i = 0; i < N; i++) begin
      int j;
      j = (m_ptr + i) % N;
      if (w < 0 && rq[j] && !m_pend[j]) w = j;
    end
    m_pend = m_pend & ~m_ack;
    m_ack = s_ack[m_t % 16];
    m_res = s_res[m_t % 16];
    s_ack[m_t % 16] = '0;
    s_res[m_t % 16] = '0;
    if (w >= 0) begin
      m_pend[w] = 1'b1;
      m_ptr = (w + 1) % N;
      m_ga = a[w];
      m_gb = b[w];
      s_ack[(m_t + LAT) % 16] = 4'(1 << w);
      s_res[(m_t + LAT) % 16] = (a[w] & b[w]) ? 4'(1 << w) : 4'h0;
    end else begin
      m_ga = 1'b0;
      m_gb = 1'b0;
    end
    m_t++;
  endtask
  initial begin
    logic [3:0] pq, pa, pb, rq, a, b;
    logic r;
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 4'h1, 4'h1, 4'h1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1};
    tbl[2]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1};
    tbl[3]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1};
    tbl[4]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[5]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1};
    tbl[8]  = '{1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 4'h1, 1'b1};
    tbl[9]  = '{1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 4'h2, 4'h2, 1'b1};
    tbl[10] = '{1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 4'h4, 4'h4, 1'b1};
    tbl[11] = '{1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 4'h8, 4'h8, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1};
    tbl[13] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 4'h2, 1'b1};
    tbl[14] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[15] = '{1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    tbl[16] = '{1'b0, 4'h6, 4'h6, 4'h2, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1};
    tbl[17] = '{1'b0, 4'h6, 4'h6, 4'h2, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1};
    tbl[18] = '{1'b0, 4'h6, 4'h6, 4'h2, 1'b0, 1'b0, 4'h2, 4'h2, 1'b1};
    tbl[19] = '{1'b0, 4'h6, 4'h6, 4'h2, 1'b0, 1'b0, 4'h4, 4'h0, 1'b1};
    tbl[20] = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0};
    sif.req = '0; sif.op_a = '0; sif.op_b = '0;
    lif.req = '0; lif.op_a = '0; lif.op_b = '0;
    #1;
    chk("por_ack", 32'(sif.ack), 32'h0);
    step(1'b1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].req, tbl[i].a, tbl[i].b);
      chk_main($sformatf("tbl%0d", i), tbl[i].ga, tbl[i].gb, tbl[i].ack, tbl[i].res, tbl[i].busy);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h0, 4'hF, 4'hF);
      chk_main($sformatf("idle%0d", i), 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    end
`ifdef SHARED_GATE_ARB_CHECK_EN
    chk("err_clean", 32'(sif.err), 32'h0);
    force_y = 1'b1;
    step(1'b0, 4'h0, 4'h0, 4'h0);
    chk("err_set", 32'(sif.err), 32'h1);
    force_y = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 4'h0);
    chk("err_sticky", 32'(sif.err), 32'h1);
    step(1'b1, 4'h0, 4'h0, 4'h0);
    chk("err_rst", 32'(sif.err), 32'h0);
`endif
    step(1'b1, 4'h0, 4'h0, 4'h0);
    step(1'b0, 4'h3, 4'h3, 4'h3);
    chk_main("mid_g0", 1'b1, 1'b1, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h3, 4'h3, 4'h3);
    #2;
    rst = 1'b1;
    #1;
    chk_main("mid_rst", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 4'h3, 4'h3, 4'h3);
    chk_main("mid_hold", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h3, 4'h3, 4'h3);
    chk_main("mid_re0", 1'b1, 1'b1, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h3, 4'h3, 4'h3);
    chk_main("mid_re1", 1'b1, 1'b1, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 4'h0, 4'h0);
    chk_main("mid_re2", 1'b0, 1'b0, 4'h1, 4'h1, 1'b1);
    step(1'b1, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    lif.req = 4'h8; lif.op_a = 4'h8; lif.op_b = 4'h0;
    @(posedge clk); #1;
    chk("lat1_ga", 32'(lif.gate_a), 32'h1);
    chk("lat1_gb", 32'(lif.gate_b), 32'h0);
    chk("lat1_ack_early", 32'(lif.ack), 32'h0);
    lif.req = 4'h0;
    @(posedge clk); #1;
    chk("lat1_ack", 32'(lif.ack), 32'h8);
    chk("lat1_res", 32'(lif.res), 32'h0);
    lif.req = 4'h8; lif.op_a = 4'h8; lif.op_b = 4'h8;
    @(posedge clk); #1;
    chk("lat1_masked", 32'(lif.gate_a), 32'h0);
    @(posedge clk); #1;
    chk("lat1_regrant", 32'({lif.gate_a, lif.gate_b}), 32'h3);
    lif.req = 4'h0;
    @(posedge clk); #1;
    chk("lat1_ack2", 32'(lif.ack), 32'h8);
    chk("lat1_res2", 32'(lif.res), 32'h8);
    model_edge(1'b1, 4'h0, 4'h0, 4'h0);
    step(1'b1, 4'h0, 4'h0, 4'h0);
    pq = '0; pa = '0; pb = '0;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 59) == 0);
      rq = 4'($urandom_range(0, 15));
      a = (pa & pq & rq) | (4'($urandom) & ~(pq & rq));
      b = (pb & pq & rq) | (4'($urandom) & ~(pq & rq));
      model_edge(r, rq, a, b);
      step(r, rq, a, b);
      chk_main($sformatf("rnd%0d", c), m_ga, m_gb, m_ack, m_res, |m_pend);
      pq = rq; pa = a; pb = b;
    end
`ifdef SHARED_GATE_ARB_CHECK_EN
    chk("err_rnd", 32'(sif.err), 32'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
